rv_mul_issue: RTL and testbench

//  Issue/retire controller for the M-extension multiply path in the EX stage.

---
 rtl/rv_pkg.sv | 20 ++
 rtl/rv_mul_post.sv | 26 ++
 rtl/rv_mul_issue.sv | 162 ++++++++++++++++
 tb/tb_rv_mul_issue.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared encodings for the M-extension multiply issue path.
package rv_pkg;

  // funct3 encodings of the multiply ops handled here
  localparam logic [2:0] MUL_OP_MUL    = 3'b000;
  localparam logic [2:0] MUL_OP_MULH   = 3'b001;
  localparam logic [2:0] MUL_OP_MULHSU = 3'b010;
  localparam logic [2:0] MUL_OP_MULHU  = 3'b011;

  // Issue FSM encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Magnitude of a signed 64-bit value; INT64_MIN maps to 2^63 as unsigned.
  function automatic logic [63:0] abs64(input logic [63:0] x);
    return x[63] ? (~x + 64'd1) : x;
  endfunction

endpackage

// File: rtl/rv_mul_post.sv
// Product post-processing: optional negate, half select, W sign-extend.
module rv_mul_post
  import rv_pkg::*;
(
  input  logic [127:0] prod,
  input  logic         neg,
  input  logic         word,
  input  logic [2:0]   op,
  output logic [63:0]  data
);

  logic [127:0] p;

  // Apply the recorded sign, then pick the part of the product the op returns
  always_comb begin
    p = neg ? (~prod + 128'd1) : prod;
    if (word) begin
      data = {{32{p[31]}}, p[31:0]};
    end else if (op == MUL_OP_MUL) begin
      data = p[63:0];
    end else begin
      data = p[127:64];
    end
  end

endmodule

// File: rtl/rv_mul_issue.sv
// Issue/retire controller for the EX-stage multiply path. Conditions operands for an
// external unsigned 64x64 multiplier of latency MUL_LAT and holds the result for
// writeback. Optional macro MUL_FASTPATH_EN: zero operand retires in one cycle.
module rv_mul_issue
  import rv_pkg::*;
#(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic [2:0]   req_op_i,
  input  logic         req_word_i,
  input  logic [63:0]  req_rs1_i,
  input  logic [63:0]  req_rs2_i,
  input  logic [4:0]   req_rd_i,
  input  logic         flush_i,
  output logic [63:0]  mul_op1_o,
  output logic [63:0]  mul_op2_o,
  input  logic [127:0] mul_prod_i,
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic [63:0]  rsp_data_o,
  output logic [4:0]   rsp_rd_o,
  output logic         busy_o
);

  localparam int unsigned CNT_W = $clog2(MUL_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      op1_q, op2_q, data_q;
  logic [2:0]       op_q, op_n;
  logic             word_q, neg_q, neg_n;
  logic [4:0]       rd_q;
  logic [63:0]      cond1, cond2, post_data;
  logic             accept, fast, capture;

  assign req_ready_o = !flush_i && ((state_q == ST_IDLE) ||
                                    ((state_q == ST_DONE) && rsp_ready_i));
  assign accept  = req_valid_i && req_ready_o;
  assign capture = (state_q == ST_BUSY) && (cnt_q == CNT_LAST) && !flush_i;

  // Normalise the op (MULW and reserved funct3 behave as MUL) and condition operands
  always_comb begin
    op_n = req_op_i;
    if (req_word_i || req_op_i[2]) op_n = MUL_OP_MUL;
    cond1 = req_rs1_i;
    cond2 = req_rs2_i;
    neg_n = 1'b0;
    case (op_n)
      MUL_OP_MULH: begin
        cond1 = abs64(req_rs1_i);
        cond2 = abs64(req_rs2_i);
        neg_n = req_rs1_i[63] ^ req_rs2_i[63];
      end
      MUL_OP_MULHSU: begin
        cond1 = abs64(req_rs1_i);
        neg_n = req_rs1_i[63];
      end
      default: ;
    endcase
  end

`ifdef MUL_FASTPATH_EN
  assign fast = (cond1 == 64'd0) || (cond2 == 64'd0);
`else
  assign fast = 1'b0;
`endif

  // Next-state logic for the issue FSM and latency counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_d = fast ? ST_DONE : ST_BUSY;
            cnt_d   = '0;
          end
        end
        ST_BUSY: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (rsp_ready_i) begin
            // A request in the retire cycle issues straight away
            if (accept) begin
              state_d = fast ? ST_DONE : ST_BUSY;
            end else begin
              state_d = ST_IDLE;
            end
            cnt_d = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, request capture and result capture registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      op_q    <= MUL_OP_MUL;
      word_q  <= 1'b0;
      neg_q   <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_q   <= op_n;
        word_q <= req_word_i;
        neg_q  <= neg_n;
        rd_q   <= req_rd_i;
        // Fast-path ops leave the multiplier inputs untouched
        if (fast) begin
          data_q <= '0;
        end else begin
          op1_q <= cond1;
          op2_q <= cond2;
        end
      end
      if (capture) data_q <= post_data;
    end
  end

  rv_mul_post u_post (
    .prod (mul_prod_i),
    .neg  (neg_q),
    .word (word_q),
    .op   (op_q),
    .data (post_data)
  );

  assign mul_op1_o   = op1_q;
  assign mul_op2_o   = op2_q;
  assign rsp_valid_o = (state_q == ST_DONE);
  assign rsp_data_o  = data_q;
  assign rsp_rd_o    = rd_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rv_mul_issue.sv
// Directed bench for rv_mul_issue with a behavioural pipelined multiplier.
module tb_rv_mul_issue;

  localparam int unsigned MUL_LAT = 3;
`ifdef MUL_FASTPATH_EN
  localparam int FAST_LAT = 1;
`else
  localparam int FAST_LAT = MUL_LAT + 1;
`endif

  logic         clk, rstn;
  logic         req_valid, req_ready, req_word, flush, rsp_valid, rsp_ready, busy;
  logic [2:0]   req_op;
  logic [63:0]  req_rs1, req_rs2, mul_op1, mul_op2, rsp_data;
  logic [4:0]   req_rd, rsp_rd;
  logic [127:0] mul_prod;
  logic [127:0] pipe0, pipe1;

  int n_vec = 0;
  int n_err = 0;

  rv_mul_issue #(.MUL_LAT(MUL_LAT)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_op_i    (req_op),
    .req_word_i  (req_word),
    .req_rs1_i   (req_rs1),
    .req_rs2_i   (req_rs2),
    .req_rd_i    (req_rd),
    .flush_i     (flush),
    .mul_op1_o   (mul_op1),
    .mul_op2_o   (mul_op2),
    .mul_prod_i  (mul_prod),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_rd_o    (rsp_rd),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Product is valid in the last counting cycle of the issue FSM
  always @(posedge clk) begin
    pipe0 <= {64'd0, mul_op1} * {64'd0, mul_op2};
    pipe1 <= pipe0;
  end
  assign mul_prod = pipe1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 12) begin
      step();
      lat++;
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic word, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] rd);
    req_op = op; req_word = word; req_rs1 = a; req_rs2 = b; req_rd = rd;
    req_valid = 1'b1;
    #1;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic word,
                        input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                        input logic [63:0] exp, input int exp_lat);
    int lat;
    drive(op, word, a, b, rd);
    check({tag, " ready"}, 128'(req_ready), 128'd1);
    step();
    req_valid = 1'b0;
    check({tag, " busy"}, 128'(busy), 128'd1);
    wait_valid(lat);
    check({tag, " latency"}, 128'(lat), 128'(exp_lat));
    check({tag, " data"}, 128'(rsp_data), 128'(exp));
    check({tag, " rd"}, 128'(rsp_rd), 128'(rd));
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({tag, " retired"}, 128'(rsp_valid), 128'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " rsp_valid"}, 128'(rsp_valid), 128'd0);
    check({tag, " rsp_data"}, 128'(rsp_data), 128'd0);
    check({tag, " rsp_rd"}, 128'(rsp_rd), 128'd0);
    check({tag, " mul_op1"}, 128'(mul_op1), 128'd0);
    check({tag, " mul_op2"}, 128'(mul_op2), 128'd0);
    check({tag, " busy"}, 128'(busy), 128'd0);
    check({tag, " req_ready"}, 128'(req_ready), 128'd1);
  endtask

  initial begin
    int lat;
    logic seen;
    rstn = 1'b0; req_valid = 1'b0; req_op = 3'b000; req_word = 1'b0;
    req_rs1 = '0; req_rs2 = '0; req_rd = '0; flush = 1'b0; rsp_ready = 1'b0;
    #12;
    check_reset_outputs("reset");
    rstn = 1'b1;
    step();

    // Arithmetic of each op
    run_op("mul",    3'b000, 1'b0, 64'd11424, -64'sd22338, 5'd1, 64'hFFFFFFFFF0CA1EC0, 4);
    run_op("mulh",   3'b001, 1'b0, 64'd11424, -64'sd22338, 5'd2, 64'hFFFFFFFFFFFFFFFF, 4);
    run_op("mulhu",  3'b011, 1'b0, '1, '1, 5'd3, 64'hFFFFFFFFFFFFFFFE, 4);
    run_op("mulhmin", 3'b001, 1'b0, 64'h8000000000000000, 64'h8000000000000000, 5'd4,
           64'h4000000000000000, 4);
    run_op("mulhsu", 3'b010, 1'b0, '1, 64'd2, 5'd5, 64'hFFFFFFFFFFFFFFFF, 4);
    run_op("mulw",   3'b011, 1'b1, 64'hDEADBEEF7FFFFFFF, 64'h0000000100000002, 5'd6,
           64'hFFFFFFFFFFFFFFFE, 4);
    run_op("rsvd",   3'b110, 1'b0, 64'd11424, -64'sd22338, 5'd7, 64'hFFFFFFFFF0CA1EC0, 4);
    run_op("zero",   3'b000, 1'b0, 64'd0, 64'h1234, 5'd8, 64'd0, FAST_LAT);

    // Backpressure, then back-to-back issue in the retire cycle
    drive(3'b000, 1'b0, 64'd100, 64'd7, 5'd9);
    step();
    req_valid = 1'b0;
    wait_valid(lat);
    check("bp latency", 128'(lat), 128'd4);
    drive(3'b011, 1'b0, '1, '1, 5'd10);
    for (int i = 0; i < 5; i++) begin
      check("bp valid", 128'(rsp_valid), 128'd1);
      check("bp data", 128'(rsp_data), 128'd700);
      check("bp rd", 128'(rsp_rd), 128'd9);
      check("bp req_ready", 128'(req_ready), 128'd0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    check("b2b req_ready", 128'(req_ready), 128'd1);
    step();
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("b2b busy state", 128'(rsp_valid), 128'd0);
    wait_valid(lat);
    check("b2b latency", 128'(lat), 128'd4);
    check("b2b data", 128'(rsp_data), 128'hFFFFFFFFFFFFFFFE);
    check("b2b rd", 128'(rsp_rd), 128'd10);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Flush while BUSY
    drive(3'b001, 1'b0, 64'd11424, -64'sd22338, 5'd11);
    step();
    req_valid = 1'b0;
    check("cond op1", 128'(mul_op1), 128'd11424);
    check("cond op2", 128'(mul_op2), 128'd22338);
    step();
    flush = 1'b1;
    #1;
    check("flush ready", 128'(req_ready), 128'd0);
    step();
    flush = 1'b0;
    check("flush busy", 128'(busy), 128'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen = seen | rsp_valid;
      step();
    end
    check("flush no rsp", 128'(seen), 128'd0);

    // Request presented during a flush is dropped
    drive(3'b000, 1'b0, 64'd3, 64'd5, 5'd12);
    flush = 1'b1;
    #1;
    check("flushreq ready", 128'(req_ready), 128'd0);
    step();
    req_valid = 1'b0;
    flush = 1'b0;
    check("flushreq busy", 128'(busy), 128'd0);

    // Asynchronous reset in the middle of an op
    drive(3'b000, 1'b0, 64'd3, 64'd5, 5'd13);
    step();
    req_valid = 1'b0;
    step();
    #2;
    rstn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    rstn = 1'b1;
    step();
    check("post reset idle", 128'(busy), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
